// File: rtl/gpio_pkg.sv
// gpio_pkg: shared definitions for the gpio_mmio responder.
//   - Byte offsets of the four CPU-visible registers.
//   - Bus FSM state type.
//   - Debounce counter width helper.
package gpio_pkg;

  localparam logic [3:0] GPIO_OFF_LED   = 4'h0;
  localparam logic [3:0] GPIO_OFF_SW    = 4'h4;
  localparam logic [3:0] GPIO_OFF_EDGE  = 4'h8;
  localparam logic [3:0] GPIO_OFF_IRQEN = 4'hC;

  typedef enum logic {
    IDLE,
    RESP
  } bus_state_e;

  // Wide enough to hold db_cycles itself, so cnt + 1 never wraps before the compare.
  function automatic int unsigned db_cnt_width(input int unsigned db_cycles);
    return (db_cycles < 2) ? 1 : $clog2(db_cycles + 1);
  endfunction

endpackage

// File: rtl/switch_debounce.sv
// switch_debounce: one raw switch bit -> 2-flop synchronizer -> debounce counter.
// Ports:
//   i_clk, i_rst  clock, asynchronous active-high reset
//   i_sw          raw asynchronous switch input
//   o_db          debounced level (registered)
//   o_rise        one-cycle pulse, high in the cycle before o_db goes 0->1, so a
//                 register sampling it updates on the same edge as o_db
module switch_debounce
  import gpio_pkg::*;
#(
  parameter int unsigned DB_CYCLES = 16
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_sw,
  output logic o_db,
  output logic o_rise
);

  localparam int unsigned    CntW   = db_cnt_width(DB_CYCLES);
  localparam logic [CntW-1:0] CntMax = CntW'(DB_CYCLES);

  logic            r_sync1;
  logic            r_sync2;
  logic            r_db;
  logic [CntW-1:0] r_cnt;
  logic [CntW-1:0] w_cnt_inc;
  logic            w_flip;

  assign w_cnt_inc = r_cnt + CntW'(1);
  assign w_flip    = (r_sync2 != r_db) && (w_cnt_inc == CntMax);
  assign o_rise    = w_flip && !r_db;
  assign o_db      = r_db;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_db    <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_sw;
      r_sync2 <= r_sync1;
      if (r_sync2 == r_db) begin
        r_cnt <= '0;
      end else if (w_flip) begin
        r_cnt <= '0;
        r_db  <= ~r_db;
      end else begin
        r_cnt <= w_cnt_inc;
      end
    end
  end

endmodule

// File: rtl/gpio_mmio.sv
// gpio_mmio: memory-mapped GPIO responder on the CPU data bus.
//   0x0 LED (RW), 0x4 SW (RO, debounced), 0x8 EDGE (W1C rising edges), 0xC IRQ_EN (RW).
// Ports:
//   CLK, RST            clock, asynchronous active-high reset
//   req, we, addr, wdata bus request (held until ready), direction, byte offset, data
//   rdata, ready        read data (zero unless ready), one-cycle completion pulse
//   SW                  raw switches
//   LED                 registered LED drive
//   irq                 level interrupt, |(EDGE & IRQ_EN)
module gpio_mmio
  import gpio_pkg::*;
#(
  parameter int unsigned DB_CYCLES = 16,
  parameter int unsigned BASE_SEL  = 0
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        req,
  input  logic        we,
  input  logic [3:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  input  logic [7:0]  SW,
  output logic [7:0]  LED,
  output logic        irq
);

  bus_state_e r_state;
  bus_state_e w_state_d;
  logic       w_cap;
  logic       w_ready;

  logic [7:0] r_led;
  logic [7:0] r_irq_en;
  logic [7:0] r_edge;
  logic [7:0] r_rdata;
  logic [7:0] w_sw_db;
  logic [7:0] w_rise;
  logic [7:0] w_rd_sel;
  logic [7:0] w_w1c;
  logic [7:0] w_edge_d;
  logic [3:0] w_off;
  logic       w_unused;

  // The block only sees word offsets; byte lanes, upper data and BASE_SEL are don't-care.
  assign w_unused = ^{wdata[31:8], addr[1:0], 32'(BASE_SEL)};
  assign w_off    = {addr[3:2], 2'b00};

  for (genvar gi = 0; gi < 8; gi++) begin : g_sw
    switch_debounce #(
      .DB_CYCLES(DB_CYCLES)
    ) u_debounce (
      .i_clk (CLK),
      .i_rst (RST),
      .i_sw  (SW[gi]),
      .o_db  (w_sw_db[gi]),
      .o_rise(w_rise[gi])
    );
  end

  always_comb begin
    w_state_d = r_state;
    w_cap     = 1'b0;
    w_ready   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (req) begin
          w_cap     = 1'b1;
          w_state_d = RESP;
        end
      end
      RESP: begin
        w_ready   = 1'b1;
        w_state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    w_rd_sel = '0;
    unique case (w_off)
      GPIO_OFF_LED:   w_rd_sel = r_led;
      GPIO_OFF_SW:    w_rd_sel = w_sw_db;
      GPIO_OFF_EDGE:  w_rd_sel = r_edge;
      GPIO_OFF_IRQEN: w_rd_sel = r_irq_en;
      default:        w_rd_sel = '0;
    endcase
  end

  // OR-ing the rise after the clear makes a same-edge set win over W1C.
  assign w_w1c    = (w_cap && we && (w_off == GPIO_OFF_EDGE)) ? wdata[7:0] : 8'h00;
  assign w_edge_d = (r_edge & ~w_w1c) | w_rise;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_led    <= '0;
      r_irq_en <= '0;
      r_edge   <= '0;
      r_rdata  <= '0;
    end else begin
      r_edge <= w_edge_d;
      if (w_cap) begin
        // Read data is the pre-write value, even for a write to the same register.
        r_rdata <= w_rd_sel;
        if (we && (w_off == GPIO_OFF_LED)) begin
          r_led <= wdata[7:0];
        end
        if (we && (w_off == GPIO_OFF_IRQEN)) begin
          r_irq_en <= wdata[7:0];
        end
      end
    end
  end

  assign ready = w_ready;
  assign rdata = w_ready ? {24'h0, r_rdata} : 32'h0;
  assign LED   = r_led;
  assign irq   = |(r_edge & r_irq_en);

endmodule

// File: tb/tb_gpio_mmio.sv
module tb_gpio_mmio;

  localparam int unsigned DB = 16;

  logic        CLK   = 1'b0;
  logic        RST   = 1'b1;
  logic        req   = 1'b0;
  logic        we    = 1'b0;
  logic [3:0]  addr  = 4'h0;
  logic [31:0] wdata = 32'h0;
  logic [7:0]  SW    = 8'h00;
  logic [31:0] rdata;
  logic        ready;
  logic [7:0]  LED;
  logic        irq;

  int total = 0;
  int bad   = 0;

  gpio_mmio #(
    .DB_CYCLES(DB),
    .BASE_SEL (0)
  ) dut (
    .CLK  (CLK),
    .RST  (RST),
    .req  (req),
    .we   (we),
    .addr (addr),
    .wdata(wdata),
    .rdata(rdata),
    .ready(ready),
    .SW   (SW),
    .LED  (LED),
    .irq  (irq)
  );

  always #5 CLK = ~CLK;

  // Reference model state
  logic [7:0]  m_led, m_ien, m_edge, m_db, m_new_db;
  logic        m_resp, m_cap, m_alldiff;
  logic [7:0]  m_hist [0:DB];  // m_hist[0] = raw SW sampled on the previous edge
  logic [31:0] exp_q [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, required %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] m_reg(input logic [1:0] w);
    case (w)
      2'd0:    return m_led;
      2'd1:    return m_db;
      2'd2:    return m_edge;
      default: return m_ien;
    endcase
  endfunction

  // Model: a debounced bit flips once the last DB synchronized samples (raw delayed by
  // two edges) all disagree with it; EDGE records 0->1 flips; one transaction per 2 cycles.
  initial begin
    forever begin
      @(posedge CLK);
      if (RST) begin
        m_led  = 8'h00;
        m_ien  = 8'h00;
        m_edge = 8'h00;
        m_db   = 8'h00;
        m_resp = 1'b0;
        for (int j = 0; j <= DB; j++) m_hist[j] = 8'h00;
        exp_q.delete();
      end else begin
        m_cap = req && !m_resp;
        if (m_cap) exp_q.push_back({24'h0, m_reg(addr[3:2])});
        m_new_db = m_db;
        for (int i = 0; i < 8; i++) begin
          m_alldiff = 1'b1;
          for (int j = 1; j <= DB; j++) if (m_hist[j][i] == m_db[i]) m_alldiff = 1'b0;
          if (m_alldiff) m_new_db[i] = ~m_db[i];
        end
        if (m_cap && we) begin
          case (addr[3:2])
            2'd0:    m_led  = wdata[7:0];
            2'd2:    m_edge = m_edge & ~wdata[7:0];
            2'd3:    m_ien  = wdata[7:0];
            default: ;
          endcase
        end
        m_edge = m_edge | (m_new_db & ~m_db);
        m_db   = m_new_db;
        for (int j = DB; j > 0; j--) m_hist[j] = m_hist[j-1];
        m_hist[0] = SW;
        m_resp    = m_cap;
      end
    end
  end

  // Monitor / scoreboard
  initial begin
    logic [31:0] e;
    forever begin
      @(posedge CLK);
      #1;
      if (!RST) begin
        chk("ready", 32'(ready), 32'(m_resp));
        chk("LED", 32'(LED), 32'(m_led));
        chk("irq", 32'(irq), 32'(|(m_edge & m_ien)));
        if (ready) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL spurious_ready: got ready=1 rdata=%h, required no response", rdata);
          end else begin
            e = exp_q.pop_front();
            chk("rdata", rdata, e);
          end
        end else begin
          chk("rdata_idle", rdata, 32'h0);
        end
      end
    end
  end

  task automatic bus(input logic w, input logic [3:0] a, input logic [31:0] d,
                     output logic [31:0] rd);
    bit got;
    got = 1'b0;
    rd  = 32'hx;
    @(negedge CLK);
    req = 1'b1; we = w; addr = a; wdata = d;
    for (int k = 0; k < 8 && !got; k++) begin
      @(negedge CLK);
      if (ready) begin
        got = 1'b1;
        rd  = rdata;
      end
    end
    req = 1'b0;
    we  = 1'b0;
    if (!got) begin
      total++;
      bad++;
      $display("FAIL bus_timeout: addr=%h got no ready, required ready within 8 cycles", a);
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    logic [31:0] v;
    bus(1'b1, a, d, v);
  endtask

  task automatic rd_chk(input string nm, input logic [3:0] a, input logic [31:0] exp);
    logic [31:0] v;
    bus(1'b0, a, 32'h0, v);
    chk(nm, v, exp);
  endtask

  task automatic do_reset(input logic [7:0] sw);
    @(negedge CLK);
    RST = 1'b1;
    SW  = sw;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v;
    logic [31:0] swr [10];

    // Reset values
    do_reset(8'h00);
    rd_chk("rst_led", 4'h0, 32'h0);
    rd_chk("rst_sw", 4'h4, 32'h0);
    rd_chk("rst_edge", 4'h8, 32'h0);
    rd_chk("rst_irqen", 4'hC, 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);

    // LED writes
    wr(4'h0, 32'h0000_00A5);
    chk("led_a5", 32'(LED), 32'hA5);
    rd_chk("rd_led_a5", 4'h0, 32'h0000_00A5);
    wr(4'h1, 32'hFFFF_FF3C);  // low address bits ignored
    chk("led_3c", 32'(LED), 32'h3C);

    // Switch latency from reset release: reads capture on edges 2,4,...,20
    do_reset(8'h55);
    for (int k = 0; k < 10; k++) bus(1'b0, 4'h4, 32'h0, swr[k]);
    chk("sw_edge18_old", swr[8], 32'h0);
    chk("sw_edge20_new", swr[9], 32'h55);
    rd_chk("edge_55", 4'h8, 32'h55);

    // Interrupt masking and W1C
    wr(4'hC, 32'h01);
    chk("irq_en0", 32'(irq), 32'h1);
    wr(4'h8, 32'h01);
    rd_chk("edge_w1c", 4'h8, 32'h54);
    chk("irq_cleared", 32'(irq), 32'h0);
    wr(4'hC, 32'h04);
    chk("irq_en2", 32'(irq), 32'h1);
    wr(4'h4, 32'hFF);  // SW is read-only
    rd_chk("sw_ro", 4'h4, 32'h55);

    // Glitch shorter than the debounce window
    @(negedge CLK); SW = 8'hD5;
    repeat (10) @(negedge CLK);
    SW = 8'h55;
    repeat (40) @(negedge CLK);
    rd_chk("glitch_sw", 4'h4, 32'h55);
    rd_chk("glitch_edge", 4'h8, 32'h54);

    // Long hold sets EDGE[7]
    @(negedge CLK); SW = 8'hD5;
    repeat (30) @(negedge CLK);
    rd_chk("hold_edge", 4'h8, 32'hD4);
    wr(4'h8, 32'h80);
    @(negedge CLK); SW = 8'h55;
    repeat (30) @(negedge CLK);
    rd_chk("fall_edge", 4'h8, 32'h54);

    // W1C captured on the same edge as the set: set wins
    @(negedge CLK); SW = 8'hD5;
    repeat (16) @(negedge CLK);
    wr(4'h8, 32'h80);
    rd_chk("set_wins", 4'h8, 32'hD4);

    // Randomized traffic against the model
    for (int it = 0; it < 250; it++) begin
      case ($urandom_range(0, 3))
        0: begin
          @(negedge CLK);
          SW = 8'($urandom);
        end
        1: repeat ($urandom_range(1, 25)) @(negedge CLK);
        default: begin
          if ($urandom_range(0, 1) == 1) wr(4'($urandom_range(0, 15)), $urandom);
          else bus(1'b0, 4'($urandom_range(0, 15)), 32'h0, v);
        end
      endcase
    end

    // Reset during RESP
    wr(4'h0, 32'h77);
    wr(4'hC, 32'hFF);
    @(negedge CLK);
    req = 1'b1; we = 1'b0; addr = 4'h0;
    @(posedge CLK);
    #2;
    RST = 1'b1;
    req = 1'b0;
    SW  = 8'h00;
    #1;
    chk("rst_mid_ready", 32'(ready), 32'h0);
    chk("rst_mid_rdata", rdata, 32'h0);
    chk("rst_mid_led", 32'(LED), 32'h0);
    chk("rst_mid_irq", 32'(irq), 32'h0);
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    rd_chk("post_rst_led", 4'h0, 32'h0);
    rd_chk("post_rst_edge", 4'h8, 32'h0);
    rd_chk("post_rst_irqen", 4'hC, 32'h0);
    rd_chk("post_rst_sw", 4'h4, 32'h0);
    repeat (3) @(negedge CLK);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
